// File: rtl/ct_ifu_icache_predecd_refill.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ct_ifu_icache_predecd_refill
//
// Write feeder for I-cache predecode array 1. Accepts 128-bit refill beats
// into a small beat FIFO. The FIFO head is predecoded into a 32-bit word and
// moved into a single stage register. The stage entry is written to the
// predecode SRAM whenever the fetch side is not reading the array.
// Fetch reads always win the array. A saturating stall counter flags an
// urgent request when refill writes have been starved for too long.
//
// Ports
//   forever_cpuclk                    clock
//   cpurst_b                          asynchronous reset, active low
//   l1_refill_vld/rdy                 refill beat handshake
//   l1_refill_index/data/last         beat payload: array index, 8 halfwords,
//                                     end-of-line marker
//   ifctrl_read_req                   fetch owns the array this cycle
//   ifctrl_inv_req                    flush, aborts the refill in flight
//   refill_predecd_index              SRAM write index
//   ifu_icache_predecd_array1_cen_b   SRAM chip enable, active low
//   ifu_icache_predecd_array1_wen_b   SRAM write enable, active low
//   ifu_icache_predecd_array1_clk_en  SRAM local clock-gate enable
//   ifu_icache_predecd_array1_din     predecode word, 4 bits per halfword
//   refill_wr_urgent                  writes starved for STALL_MAX cycles
//   refill_predecd_busy               a refill line is in progress
//   refill_predecd_done               one-cycle pulse, line fully written
// ---------------------------------------------------------------------------
module ct_ifu_icache_predecd_refill #(
  parameter int FIFO_DEPTH = 2,
  parameter int INDEX_W    = 16,
  parameter int STALL_MAX  = 8
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               l1_refill_vld,
  output logic               l1_refill_rdy,
  input  logic [INDEX_W-1:0] l1_refill_index,
  input  logic [127:0]       l1_refill_data,
  input  logic               l1_refill_last,
  input  logic               ifctrl_read_req,
  input  logic               ifctrl_inv_req,
  output logic [INDEX_W-1:0] refill_predecd_index,
  output logic               ifu_icache_predecd_array1_cen_b,
  output logic               ifu_icache_predecd_array1_wen_b,
  output logic               ifu_icache_predecd_array1_clk_en,
  output logic [31:0]        ifu_icache_predecd_array1_din,
  output logic               refill_wr_urgent,
  output logic               refill_predecd_busy,
  output logic               refill_predecd_done
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  localparam logic [CNT_W-1:0]   FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STALL_W-1:0] STALL_SAT     = STALL_W'(STALL_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Predecode of one halfword, assuming it is the start of an instruction.
  // Bit order of the tag: {jalr, jal, br, is32}.
  function automatic logic [3:0] predecd_hw(input logic [15:0] hw);
    logic is32;
    logic br;
    logic jal;
    logic jalr;
    logic cjr;
    is32 = (hw[1:0] == 2'b11);
    br   = (is32 && (hw[6:0] == 7'b1100011)) ||
           ((hw[1:0] == 2'b01) && (hw[15:14] == 2'b11));
    jal  = (is32 && (hw[6:0] == 7'b1101111)) ||
           ((hw[1:0] == 2'b01) && (hw[15:13] == 3'b101));
    // c.jr and c.jalr differ only in hw[12], so hw[12] is a don't-care here
    cjr  = (hw[1:0] == 2'b10) && (hw[15:13] == 3'b100) &&
           (hw[6:2] == 5'd0) && (hw[11:7] != 5'd0);
    jalr = (is32 && (hw[6:0] == 7'b1100111)) || cjr;
    return {jalr, jal, br, is32};
  endfunction

  logic [127:0]       fifo_data  [FIFO_DEPTH];
  logic [INDEX_W-1:0] fifo_index [FIFO_DEPTH];
  logic               fifo_last  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic               stage_vld;
  logic [31:0]        stage_din;
  logic [INDEX_W-1:0] stage_index;
  logic               stage_last;

  logic [STALL_W-1:0] stall_cnt;
  logic [1:0]         state;
  logic [1:0]         state_nxt;

  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               wr_fire;
  logic [31:0]        head_din;

  // The ready flag looks only at the FIFO occupancy, never at a same-cycle
  // pop, so it stays free of any path from read_req through the stage.
  assign fifo_empty    = (fifo_cnt == '0);
  assign l1_refill_rdy = (fifo_cnt != FIFO_FULL_CNT) && !ifctrl_inv_req;
  assign push          = l1_refill_vld && l1_refill_rdy;

  // A write goes out whenever the stage holds data and the array is free.
  // The stage refills from the FIFO head when it is empty or being drained.
  assign wr_fire = stage_vld && !ifctrl_read_req && !ifctrl_inv_req;
  assign pop     = !fifo_empty && (!stage_vld || wr_fire) && !ifctrl_inv_req;

  // Predecode is computed on the FIFO head so the stage captures the final
  // SRAM word directly.
  always_comb begin
    head_din = '0;
    for (int h = 0; h < 8; h++) begin
      head_din[4*h +: 4] = predecd_hw(fifo_data[rd_ptr][16*h +: 16]);
    end
  end

  // Beat storage. It carries no reset because the pointers and the count
  // alone define which entries are meaningful.
  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= l1_refill_data;
      fifo_index[wr_ptr] <= l1_refill_index;
      fifo_last[wr_ptr]  <= l1_refill_last;
    end
  end

  // FIFO pointers and occupancy. A flush empties the FIFO in one cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (ifctrl_inv_req) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Predecode stage register. It holds its entry while the array is busy
  // with fetch reads and is cleared by a flush.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      stage_vld   <= 1'b0;
      stage_din   <= '0;
      stage_index <= '0;
      stage_last  <= 1'b0;
    end else if (ifctrl_inv_req) begin
      stage_vld   <= 1'b0;
      stage_din   <= '0;
      stage_index <= '0;
      stage_last  <= 1'b0;
    end else if (pop) begin
      stage_vld   <= 1'b1;
      stage_din   <= head_din;
      stage_index <= fifo_index[rd_ptr];
      stage_last  <= fifo_last[rd_ptr];
    end else if (wr_fire) begin
      stage_vld   <= 1'b0;
    end
  end

  // Starvation counter: counts cycles in which a ready write is blocked by
  // fetch, saturates, and restarts as soon as a write gets through.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      stall_cnt <= '0;
    end else if (ifctrl_inv_req || wr_fire) begin
      stall_cnt <= '0;
    end else if (stage_vld && ifctrl_read_req && (stall_cnt != STALL_SAT)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Line tracking. DONE lasts exactly one cycle; if another line has already
  // started to arrive, the FSM goes straight back to ACTIVE so busy stays
  // high while that data is still pending.
  always_comb begin
    state_nxt = state;
    if (ifctrl_inv_req) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            state_nxt = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (wr_fire && stage_last) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (push || !fifo_empty || stage_vld) begin
            state_nxt = ST_ACTIVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign ifu_icache_predecd_array1_cen_b  = !wr_fire;
  assign ifu_icache_predecd_array1_wen_b  = !wr_fire;
  assign ifu_icache_predecd_array1_clk_en = wr_fire;
  assign ifu_icache_predecd_array1_din    = stage_din;
  assign refill_predecd_index             = stage_index;
  assign refill_wr_urgent                 = (stall_cnt == STALL_SAT);
  assign refill_predecd_busy              = (state != ST_IDLE);
  assign refill_predecd_done              = (state == ST_DONE);

endmodule

// File: tb/tb_ct_ifu_icache_predecd_refill.sv
`timescale 1ns/1ps
// Self-checking bench for ct_ifu_icache_predecd_refill. Stimulus pushes the
// expected SRAM write of every accepted beat into a queue; a monitor pops and
// compares whenever the DUT issues a write.
module tb_ct_ifu_icache_predecd_refill;

  typedef struct {
    logic [15:0] idx;
    logic [31:0] din;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         vld;
  logic         rdy;
  logic [15:0]  in_index;
  logic [127:0] in_data;
  logic         in_last;
  logic         read_req;
  logic         inv_req;
  logic [15:0]  wr_index;
  logic         cen_b;
  logic         wen_b;
  logic         clk_en;
  logic [31:0]  din;
  logic         urgent;
  logic         busy;
  logic         done;

  exp_t exp_q[$];
  int   wr_cycles[$];
  int   done_cycles[$];
  int   cyc;
  int   passes;
  int   total;

  ct_ifu_icache_predecd_refill dut (
    .forever_cpuclk                   (clk),
    .cpurst_b                         (rst_n),
    .l1_refill_vld                    (vld),
    .l1_refill_rdy                    (rdy),
    .l1_refill_index                  (in_index),
    .l1_refill_data                   (in_data),
    .l1_refill_last                   (in_last),
    .ifctrl_read_req                  (read_req),
    .ifctrl_inv_req                   (inv_req),
    .refill_predecd_index             (wr_index),
    .ifu_icache_predecd_array1_cen_b  (cen_b),
    .ifu_icache_predecd_array1_wen_b  (wen_b),
    .ifu_icache_predecd_array1_clk_en (clk_en),
    .ifu_icache_predecd_array1_din    (din),
    .refill_wr_urgent                 (urgent),
    .refill_predecd_busy              (busy),
    .refill_predecd_done              (done)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, read at the negative edge to timestamp events.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every SRAM write is matched against the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (cen_b === 1'b0) begin
        wr_cycles.push_back(cyc);
        checkOutput("write_while_read", {63'd0, read_req}, 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          $display("[TB] FAIL unexpected_write: index 0x%0h din 0x%0h, expected no write (cycle %0d)",
                   wr_index, din, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_index", {48'd0, wr_index}, {48'd0, e.idx});
          checkOutput("wr_din", {32'd0, din}, {32'd0, e.din});
          checkOutput("wr_wen_b", {63'd0, wen_b}, 64'd0);
          checkOutput("wr_clk_en", {63'd0, clk_en}, 64'd1);
        end
      end
      if (done === 1'b1) begin
        done_cycles.push_back(cyc);
      end
    end
  end

  // Drives one cycle of inputs just after the rising edge, then waits for the
  // falling edge where acceptance is decided and the expectation is queued.
  task automatic applyStimulus(input logic v, input logic [15:0] idx, input logic [127:0] data,
                               input logic last, input logic rd, input logic inv,
                               input logic [31:0] exp_din, output logic accepted);
    @(posedge clk);
    #1;
    vld      = v;
    in_index = idx;
    in_data  = data;
    in_last  = last;
    read_req = rd;
    inv_req  = inv;
    @(negedge clk);
    accepted = v && rdy && rst_n;
    if (accepted) begin
      exp_q.push_back('{idx: idx, din: exp_din});
    end
    if (inv) begin
      exp_q.delete();
    end
  endtask

  task automatic idle(input logic rd);
    logic acc;
    applyStimulus(1'b0, 16'd0, 128'd0, 1'b0, rd, 1'b0, 32'd0, acc);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1'b0);
      n++;
    end
    checkOutput("drain_in_budget", {32'd0, exp_q.size()}, 64'd0);
  endtask

  function automatic logic [127:0] rep(input logic [15:0] hw);
    return {8{hw}};
  endfunction

  initial begin
    logic         acc;
    int           t0;
    logic [127:0] pd_data;
    logic [15:0]  line_hw  [4];
    logic [31:0]  line_din [4];

    cyc      = 0;
    passes   = 0;
    total    = 0;
    rst_n    = 1'b0;
    vld      = 1'b0;
    in_index = '0;
    in_data  = '0;
    in_last  = 1'b0;
    read_req = 1'b0;
    inv_req  = 1'b0;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    checkOutput("rst_rdy", {63'd0, rdy}, 64'd1);
    checkOutput("rst_cen_b", {63'd0, cen_b}, 64'd1);
    checkOutput("rst_wen_b", {63'd0, wen_b}, 64'd1);
    checkOutput("rst_clk_en", {63'd0, clk_en}, 64'd0);
    checkOutput("rst_din", {32'd0, din}, 64'd0);
    checkOutput("rst_index", {48'd0, wr_index}, 64'd0);
    checkOutput("rst_urgent", {63'd0, urgent}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;

    // ---- predecode vector, latency T+2, done at T+3 ----
    $display("[TB] predecode vector");
    wr_cycles.delete();
    done_cycles.delete();
    pd_data = {16'h0001, 16'h0001, 16'h0000, 16'h0063,
               16'h8082, 16'hA001, 16'h0000, 16'h006F};
    applyStimulus(1'b1, 16'h0005, pd_data, 1'b1, 1'b0, 1'b0, 32'h0003_8405, acc);
    t0 = cyc;
    checkOutput("pd_accepted", {63'd0, acc}, 64'd1);
    repeat (4) idle(1'b0);
    checkOutput("pd_write_count", {32'd0, wr_cycles.size()}, 64'd1);
    if (wr_cycles.size() >= 1) checkOutput("pd_latency", 64'(wr_cycles[0] - t0), 64'd2);
    checkOutput("pd_done_count", {32'd0, done_cycles.size()}, 64'd1);
    if (done_cycles.size() >= 1) checkOutput("pd_done_cycle", 64'(done_cycles[0] - t0), 64'd3);
    checkOutput("pd_busy_after", {63'd0, busy}, 64'd0);

    // ---- 4-beat line back to back ----
    $display("[TB] 4-beat line");
    wr_cycles.delete();
    done_cycles.delete();
    line_hw  = '{16'h0063, 16'h006F, 16'h9082, 16'h0067};
    line_din = '{32'h3333_3333, 32'h5555_5555, 32'h8888_8888, 32'h9999_9999};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h0010 + 16'(i), rep(line_hw[i]), (i == 3), 1'b0, 1'b0, line_din[i], acc);
      if (i == 0) t0 = cyc;
      checkOutput("line_accepted", {63'd0, acc}, 64'd1);
    end
    repeat (5) idle(1'b0);
    checkOutput("line_write_count", {32'd0, wr_cycles.size()}, 64'd4);
    if (wr_cycles.size() == 4) begin
      checkOutput("line_first_latency", 64'(wr_cycles[0] - t0), 64'd2);
      checkOutput("line_back_to_back", 64'(wr_cycles[3] - wr_cycles[0]), 64'd3);
      if (done_cycles.size() >= 1) checkOutput("line_done_cycle", 64'(done_cycles[0] - wr_cycles[3]), 64'd1);
    end
    checkOutput("line_done_count", {32'd0, done_cycles.size()}, 64'd1);
    checkOutput("line_busy_after", {63'd0, busy}, 64'd0);

    // ---- backpressure with read_req held ----
    $display("[TB] backpressure");
    wr_cycles.delete();
    applyStimulus(1'b1, 16'h0020, rep(16'hE001), 1'b0, 1'b1, 1'b0, 32'h2222_2222, acc);
    checkOutput("bp_acc0", {63'd0, acc}, 64'd1);
    applyStimulus(1'b1, 16'h0021, rep(16'h8002), 1'b0, 1'b1, 1'b0, 32'h0000_0000, acc);
    checkOutput("bp_acc1", {63'd0, acc}, 64'd1);
    applyStimulus(1'b1, 16'h0022, rep(16'h0001), 1'b0, 1'b1, 1'b0, 32'h0000_0000, acc);
    checkOutput("bp_acc2", {63'd0, acc}, 64'd1);
    applyStimulus(1'b1, 16'h0023, rep(16'h0063), 1'b0, 1'b1, 1'b0, 32'h3333_3333, acc);
    checkOutput("bp_rdy_low", {63'd0, rdy}, 64'd0);
    checkOutput("bp_busy", {63'd0, busy}, 64'd1);
    checkOutput("bp_no_write_yet", {32'd0, wr_cycles.size()}, 64'd0);
    waitDrain();
    checkOutput("bp_write_count", {32'd0, wr_cycles.size()}, 64'd3);
    applyStimulus(1'b0, 16'd0, 128'd0, 1'b0, 1'b0, 1'b1, 32'd0, acc);
    idle(1'b0);
    checkOutput("bp_idle_after_flush", {63'd0, busy}, 64'd0);

    // ---- starvation: urgent after STALL_MAX blocked cycles ----
    $display("[TB] starvation");
    applyStimulus(1'b1, 16'h0030, rep(16'h006F), 1'b1, 1'b1, 1'b0, 32'h5555_5555, acc);
    checkOutput("st_accepted", {63'd0, acc}, 64'd1);
    idle(1'b1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      checkOutput($sformatf("st_urgent_%0d", i), {63'd0, urgent}, {63'd0, (i >= 8)});
    end
    idle(1'b0);
    idle(1'b0);
    checkOutput("st_urgent_cleared", {63'd0, urgent}, 64'd0);
    checkOutput("st_drained", {32'd0, exp_q.size()}, 64'd0);
    repeat (2) idle(1'b0);

    // ---- flush during 2nd beat ----
    $display("[TB] flush");
    wr_cycles.delete();
    done_cycles.delete();
    applyStimulus(1'b1, 16'h0040, rep(16'h0063), 1'b0, 1'b0, 1'b0, 32'h3333_3333, acc);
    applyStimulus(1'b1, 16'h0041, rep(16'h006F), 1'b0, 1'b0, 1'b1, 32'h5555_5555, acc);
    checkOutput("fl_beat_rejected", {63'd0, acc}, 64'd0);
    idle(1'b0);
    checkOutput("fl_busy_low", {63'd0, busy}, 64'd0);
    checkOutput("fl_rdy_high", {63'd0, rdy}, 64'd1);
    repeat (4) idle(1'b0);
    checkOutput("fl_no_writes", {32'd0, wr_cycles.size()}, 64'd0);
    checkOutput("fl_no_done", {32'd0, done_cycles.size()}, 64'd0);

    // ---- asynchronous reset mid-line ----
    $display("[TB] reset mid-line");
    applyStimulus(1'b1, 16'h0050, rep(16'h0067), 1'b0, 1'b0, 1'b0, 32'h9999_9999, acc);
    applyStimulus(1'b1, 16'h0051, rep(16'h0067), 1'b0, 1'b0, 1'b0, 32'h9999_9999, acc);
    @(posedge clk);
    #1;
    vld = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("mr_cen_b", {63'd0, cen_b}, 64'd1);
    checkOutput("mr_wen_b", {63'd0, wen_b}, 64'd1);
    checkOutput("mr_clk_en", {63'd0, clk_en}, 64'd0);
    checkOutput("mr_rdy", {63'd0, rdy}, 64'd1);
    checkOutput("mr_busy", {63'd0, busy}, 64'd0);
    checkOutput("mr_din", {32'd0, din}, 64'd0);
    checkOutput("mr_index", {48'd0, wr_index}, 64'd0);
    checkOutput("mr_urgent", {63'd0, urgent}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cycles.delete();
    repeat (4) idle(1'b0);
    checkOutput("mr_no_writes", {32'd0, wr_cycles.size()}, 64'd0);
    checkOutput("mr_busy_after", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
